// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_light_monitor
//  Purpose  : Passive safety checker for the intersection light bus. Tracks
//             the NS_G -> NS_Y -> AR1 -> EW_G -> EW_Y -> AR2 phase sequence
//             and latches the first illegal code, conflict, out-of-order
//             transition, short phase or stuck phase it observes.
//  Revision : 1.0  initial release
// ============================================================================
module traffic_light_monitor #(
  parameter int GREEN_MIN  = 6,
  parameter int YELLOW_MIN = 2,
  parameter int ALLRED_MIN = 2,
  parameter int MAX_DWELL  = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ns_light,
  input  logic [1:0]  ew_light,
  input  logic        clr_fault,
  output logic [2:0]  phase,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [2:0]  fault_phase,
  output logic        cycle_done,
  output logic [15:0] cycles_ok
);

  // Dwell counter width is sized so MAX_DWELL itself is representable.
  localparam int c_DW = $clog2(MAX_DWELL + 1);

  localparam logic [c_DW-1:0] c_GREEN_MIN  = c_DW'(GREEN_MIN);
  localparam logic [c_DW-1:0] c_YELLOW_MIN = c_DW'(YELLOW_MIN);
  localparam logic [c_DW-1:0] c_ALLRED_MIN = c_DW'(ALLRED_MIN);
  localparam logic [c_DW-1:0] c_MAX_DWELL  = c_DW'(MAX_DWELL);
  localparam logic [c_DW-1:0] c_DWELL_ONE  = c_DW'(1);

  // Light codes on the bus.
  localparam logic [1:0] c_RED    = 2'b00;
  localparam logic [1:0] c_YELLOW = 2'b01;
  localparam logic [1:0] c_GREEN  = 2'b10;
  localparam logic [1:0] c_BAD    = 2'b11;

  // Fault codes reported on fault_code.
  localparam logic [2:0] c_FC_NONE    = 3'd0;
  localparam logic [2:0] c_FC_ILLEGAL = 3'd1;
  localparam logic [2:0] c_FC_CONFL   = 3'd2;
  localparam logic [2:0] c_FC_SEQ     = 3'd3;
  localparam logic [2:0] c_FC_SHORT   = 3'd4;
  localparam logic [2:0] c_FC_STUCK   = 3'd5;

  // Monitor states; the encoding is the externally visible phase value.
  typedef enum logic [2:0] {
    S_SYNC  = 3'd0,
    S_NS_G  = 3'd1,
    S_NS_Y  = 3'd2,
    S_AR1   = 3'd3,
    S_EW_G  = 3'd4,
    S_EW_Y  = 3'd5,
    S_AR2   = 3'd6,
    S_FAULT = 3'd7
  } state_t;

  state_t          r_state;
  logic [c_DW-1:0] r_dwell;
  logic            r_fault;
  logic [2:0]      r_fault_code;
  logic [2:0]      r_fault_phase;
  logic            r_cycle_done;
  logic [15:0]     r_cycles_ok;

  logic [1:0]      w_cur_ns;
  logic [1:0]      w_cur_ew;
  logic [1:0]      w_nxt_ns;
  logic [1:0]      w_nxt_ew;
  state_t          w_nxt_state;
  logic [c_DW-1:0] w_min;

  logic            w_illegal;
  logic            w_conflict;
  logic            w_match_cur;
  logic            w_match_nxt;
  logic            w_at_max;
  logic            w_short;
  logic            w_sync_hit;

  // Expected light pattern, successor pattern and minimum dwell of the current phase.
  always_comb begin
    w_cur_ns    = c_RED;
    w_cur_ew    = c_RED;
    w_nxt_ns    = c_RED;
    w_nxt_ew    = c_RED;
    w_nxt_state = S_SYNC;
    w_min       = c_ALLRED_MIN;
    case (r_state)
      S_NS_G: begin
        w_cur_ns    = c_GREEN;
        w_nxt_ns    = c_YELLOW;
        w_nxt_state = S_NS_Y;
        w_min       = c_GREEN_MIN;
      end
      S_NS_Y: begin
        w_cur_ns    = c_YELLOW;
        w_nxt_state = S_AR1;
        w_min       = c_YELLOW_MIN;
      end
      S_AR1: begin
        w_nxt_ew    = c_GREEN;
        w_nxt_state = S_EW_G;
        w_min       = c_ALLRED_MIN;
      end
      S_EW_G: begin
        w_cur_ew    = c_GREEN;
        w_nxt_ew    = c_YELLOW;
        w_nxt_state = S_EW_Y;
        w_min       = c_GREEN_MIN;
      end
      S_EW_Y: begin
        w_cur_ew    = c_YELLOW;
        w_nxt_state = S_AR2;
        w_min       = c_YELLOW_MIN;
      end
      S_AR2: begin
        w_nxt_ns    = c_GREEN;
        w_nxt_state = S_NS_G;
        w_min       = c_ALLRED_MIN;
      end
      default: begin
        w_nxt_state = S_SYNC;
      end
    endcase
  end

  // Classification of the current sample against the expected patterns.
  always_comb begin
    w_illegal   = (ns_light == c_BAD) || (ew_light == c_BAD);
    w_conflict  = (ns_light != c_RED) && (ew_light != c_RED);
    w_match_cur = (ns_light == w_cur_ns) && (ew_light == w_cur_ew);
    w_match_nxt = (ns_light == w_nxt_ns) && (ew_light == w_nxt_ew);
    w_at_max    = (r_dwell == c_MAX_DWELL);
    w_short     = (r_dwell < w_min);
    // X or illegal codes compare false here, so SYNC simply keeps waiting.
    w_sync_hit  = (ns_light == c_GREEN) && (ew_light == c_RED);
  end

  // Phase tracker, dwell counter, fault latch and sequence counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_SYNC;
      r_dwell       <= '0;
      r_fault       <= 1'b0;
      r_fault_code  <= c_FC_NONE;
      r_fault_phase <= 3'd0;
      r_cycle_done  <= 1'b0;
      r_cycles_ok   <= 16'd0;
    end else begin
      r_cycle_done <= 1'b0;
      if (clr_fault) begin
        // Clearing takes priority over anything detected this cycle.
        r_state       <= S_SYNC;
        r_dwell       <= '0;
        r_fault       <= 1'b0;
        r_fault_code  <= c_FC_NONE;
        r_fault_phase <= 3'd0;
      end else begin
        case (r_state)
          S_SYNC: begin
            if (w_sync_hit) begin
              r_state <= S_NS_G;
              r_dwell <= c_DWELL_ONE;
            end
          end
          S_FAULT: begin
            // Frozen until clr_fault.
          end
          default: begin
            if (w_illegal) begin
              r_state       <= S_FAULT;
              r_fault       <= 1'b1;
              r_fault_code  <= c_FC_ILLEGAL;
              r_fault_phase <= r_state;
            end else if (w_conflict) begin
              r_state       <= S_FAULT;
              r_fault       <= 1'b1;
              r_fault_code  <= c_FC_CONFL;
              r_fault_phase <= r_state;
            end else if (w_match_cur) begin
              if (w_at_max) begin
                r_state       <= S_FAULT;
                r_fault       <= 1'b1;
                r_fault_code  <= c_FC_STUCK;
                r_fault_phase <= r_state;
              end else begin
                r_dwell <= r_dwell + c_DWELL_ONE;
              end
            end else if (w_match_nxt) begin
              if (w_short) begin
                r_state       <= S_FAULT;
                r_fault       <= 1'b1;
                r_fault_code  <= c_FC_SHORT;
                r_fault_phase <= r_state;
              end else begin
                r_state <= w_nxt_state;
                r_dwell <= c_DWELL_ONE;
                // Closing AR2 completes one full sequence.
                if (r_state == S_AR2) begin
                  r_cycle_done <= 1'b1;
                  r_cycles_ok  <= r_cycles_ok + 16'd1;
                end
              end
            end else begin
              r_state       <= S_FAULT;
              r_fault       <= 1'b1;
              r_fault_code  <= c_FC_SEQ;
              r_fault_phase <= r_state;
            end
          end
        endcase
      end
    end
  end

  assign phase       = r_state;
  assign fault       = r_fault;
  assign fault_code  = r_fault_code;
  assign fault_phase = r_fault_phase;
  assign cycle_done  = r_cycle_done;
  assign cycles_ok   = r_cycles_ok;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_light_monitor
//  Purpose  : Directed-vector bench for traffic_light_monitor with an
//             in-bench reference model of the phase-sequence rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_traffic_light_monitor;

  localparam int GREEN_MIN  = 6;
  localparam int YELLOW_MIN = 2;
  localparam int ALLRED_MIN = 2;
  localparam int MAX_DWELL  = 12;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] G = 2'b10;
  localparam logic [1:0] X = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ns_light = 2'b00;
  logic [1:0]  ew_light = 2'b00;
  logic        clr_fault = 1'b0;
  logic [2:0]  phase;
  logic        fault;
  logic [2:0]  fault_code;
  logic [2:0]  fault_phase;
  logic        cycle_done;
  logic [15:0] cycles_ok;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int m_phase = 0;
  int m_dwell = 0;
  int m_fault = 0;
  int m_code = 0;
  int m_fphase = 0;
  int m_done = 0;
  int m_cnt = 0;

  // Phase table indexed 1..6: expected NS code, EW code and minimum hold.
  int pat_ns [0:6] = '{0, 2, 1, 0, 0, 0, 0};
  int pat_ew [0:6] = '{0, 0, 0, 0, 2, 1, 0};
  int pmin   [0:6] = '{0, GREEN_MIN, YELLOW_MIN, ALLRED_MIN, GREEN_MIN, YELLOW_MIN, ALLRED_MIN};

  traffic_light_monitor #(
    .GREEN_MIN (GREEN_MIN),
    .YELLOW_MIN(YELLOW_MIN),
    .ALLRED_MIN(ALLRED_MIN),
    .MAX_DWELL (MAX_DWELL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .clr_fault  (clr_fault),
    .phase      (phase),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_phase(fault_phase),
    .cycle_done (cycle_done),
    .cycles_ok  (cycles_ok)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_dwell = 0; m_fault = 0; m_code = 0;
    m_fphase = 0; m_done = 0; m_cnt = 0;
  endfunction

  function automatic void model_fault(input int code);
    m_fault  = 1;
    m_code   = code;
    m_fphase = m_phase;
    m_phase  = 7;
  endfunction

  // One clock of the sequence rules applied to a sample.
  function automatic void model_step(input int ns, input int ew, input int clr);
    int nxt;
    m_done = 0;
    if (clr != 0) begin
      m_phase = 0; m_dwell = 0; m_fault = 0; m_code = 0; m_fphase = 0;
    end else if (m_phase == 0) begin
      if (ns == 2 && ew == 0) begin
        m_phase = 1;
        m_dwell = 1;
      end
    end else if (m_phase != 7) begin
      nxt = (m_phase % 6) + 1;
      if (ns == 3 || ew == 3) model_fault(1);
      else if (ns != 0 && ew != 0) model_fault(2);
      else if (ns == pat_ns[m_phase] && ew == pat_ew[m_phase]) begin
        if (m_dwell == MAX_DWELL) model_fault(5);
        else m_dwell = m_dwell + 1;
      end else if (ns == pat_ns[nxt] && ew == pat_ew[nxt]) begin
        if (m_dwell < pmin[m_phase]) model_fault(4);
        else begin
          if (m_phase == 6) begin
            m_done = 1;
            m_cnt  = (m_cnt + 1) % 65536;
          end
          m_phase = nxt;
          m_dwell = 1;
        end
      end else model_fault(3);
    end
  endfunction

  // Compare all outputs to the model every cycle, away from the active edge.
  always @(negedge clk) begin
    check("phase",       int'(phase),       m_phase);
    check("fault",       int'(fault),       m_fault);
    check("fault_code",  int'(fault_code),  m_code);
    check("fault_phase", int'(fault_phase), m_fphase);
    check("cycle_done",  int'(cycle_done),  m_done);
    check("cycles_ok",   int'(cycles_ok),   m_cnt);
  end

  task automatic step(input logic [1:0] ns, input logic [1:0] ew, input logic clr);
    @(negedge clk);
    ns_light  = ns;
    ew_light  = ew;
    clr_fault = clr;
    @(posedge clk);
    model_step(int'(ns), int'(ew), int'(clr));
    #1;
  endtask

  task automatic hold(input logic [1:0] ns, input logic [1:0] ew, input int n);
    for (int i = 0; i < n; i++) step(ns, ew, 1'b0);
  endtask

  task automatic full_sequence();
    hold(G, R, 6); hold(Y, R, 2); hold(R, R, 2);
    hold(R, G, 6); hold(R, Y, 2); hold(R, R, 2);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_phase", int'(phase), 0);
    check("reset_fault", int'(fault), 0);
    check("reset_cycles_ok", int'(cycles_ok), 0);

    // Nominal: two full sequences; the second closes on the next NS green.
    full_sequence();
    full_sequence();
    step(G, R, 1'b0);
    check("nominal_cycles_ok", int'(cycles_ok), 2);
    check("nominal_phase", int'(phase), 1);
    check("nominal_fault", int'(fault), 0);

    // Conflict in EW_G, later inputs ignored.
    hold(G, R, 5); hold(Y, R, 2); hold(R, R, 2); hold(R, G, 3);
    step(G, G, 1'b0);
    check("conflict_code", int'(fault_code), 2);
    check("conflict_fphase", int'(fault_phase), 4);
    check("conflict_phase", int'(phase), 7);
    hold(G, R, 3); hold(X, X, 2);
    check("conflict_frozen_code", int'(fault_code), 2);

    // Short green (5 cycles) then exact minimum green (6 cycles).
    step(R, R, 1'b1);
    check("clr_phase", int'(phase), 0);
    hold(G, R, 5); step(Y, R, 1'b0);
    check("short_code", int'(fault_code), 4);
    check("short_fphase", int'(fault_phase), 1);
    step(R, R, 1'b1);
    hold(G, R, 6); step(Y, R, 1'b0);
    check("min_green_fault", int'(fault), 0);
    check("min_green_phase", int'(phase), 2);

    // Skipped yellow, then illegal code after resync.
    step(R, R, 1'b1);
    hold(G, R, 6); step(R, R, 1'b0);
    check("skip_code", int'(fault_code), 3);
    step(R, R, 1'b1);
    step(G, R, 1'b0); step(X, R, 1'b0);
    check("illegal_code", int'(fault_code), 1);
    check("illegal_fphase", int'(fault_phase), 1);

    // Stuck in AR1: 13th matching sample faults.
    step(R, R, 1'b1);
    hold(G, R, 6); hold(Y, R, 2); hold(R, R, 12);
    check("max_dwell_ok", int'(fault), 0);
    step(R, R, 1'b0);
    check("stuck_code", int'(fault_code), 5);
    check("stuck_fphase", int'(fault_phase), 3);
    // Rerun with clr_fault on the 13th sample.
    step(R, R, 1'b1);
    hold(G, R, 6); hold(Y, R, 2); hold(R, R, 12);
    step(R, R, 1'b1);
    check("clr_wins_fault", int'(fault), 0);
    check("clr_wins_phase", int'(phase), 0);

    // Reset mid-operation with cycles_ok = 3, while in NS_Y.
    full_sequence();
    step(G, R, 1'b0);
    check("pre_reset_cycles_ok", int'(cycles_ok), 3);
    hold(G, R, 5); step(Y, R, 1'b0);
    check("pre_reset_phase", int'(phase), 2);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_phase", int'(phase), 0);
    check("async_rst_cycles_ok", int'(cycles_ok), 0);
    check("async_rst_fault", int'(fault), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    hold(R, G, 3);
    check("sync_ignores_rg", int'(phase), 0);
    step(G, R, 1'b0);
    check("sync_enter_nsg", int'(phase), 1);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
